// File: rtl/gray_decode_accum.sv
// Bit-serial gray-to-binary decoder (MSB first) feeding a running accumulator
// with a sticky overflow flag and a saturating word counter.
module gray_decode_accum #(
  parameter int WIDTH = 5,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Greyin,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr_acc,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_valid,
  output logic [ACC_W-1:0] acc,
  output logic             overflow,
  output logic [3:0]       count
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] gray_sr;
  logic [WIDTH-1:0] bin_sr;
  logic [IDX_W-1:0] idx;

  logic             bin_bit;
  logic [WIDTH-1:0] word;
  logic             last_bit;
  logic [ACC_W-1:0] acc_base;
  logic             ovf_base;
  logic [3:0]       count_base;
  logic [ACC_W:0]   sum;

  // bin_sr[0] holds the previously decoded (more significant) bit; it is
  // zeroed on capture so the first step yields b[WIDTH-1] = g[WIDTH-1].
  always_comb begin
    bin_bit  = bin_sr[0] ^ gray_sr[WIDTH-1];
    word     = {bin_sr[WIDTH-2:0], bin_bit};
    last_bit = (state == SHIFT) && (idx == '0);
  end

  // A clear coincident with the final decode step is applied first, so the
  // new word lands on a zeroed accumulator.
  always_comb begin
    acc_base   = clr_acc ? '0 : acc;
    ovf_base   = clr_acc ? 1'b0 : overflow;
    count_base = clr_acc ? 4'd0 : count;
    sum        = {1'b0, acc_base} + {{(ACC_W + 1 - WIDTH){1'b0}}, word};
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (idx == '0) state_next = DONE;
      end
      DONE: begin
        out_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gray_sr  <= '0;
      bin_sr   <= '0;
      idx      <= '0;
      bin_out  <= '0;
      acc      <= '0;
      overflow <= 1'b0;
      count    <= 4'd0;
    end else begin
      if (state == IDLE && in_valid) begin
        gray_sr <= Greyin;
        bin_sr  <= '0;
        idx     <= IDX_W'(WIDTH - 1);
      end else if (state == SHIFT) begin
        gray_sr <= gray_sr << 1;
        bin_sr  <= word;
        idx     <= idx - 1'b1;
      end

      if (last_bit) begin
        bin_out  <= word;
        acc      <= sum[ACC_W-1:0];
        overflow <= ovf_base | sum[ACC_W];
        count    <= (count_base == 4'd15) ? count_base : count_base + 4'd1;
      end else if (clr_acc) begin
        acc      <= '0;
        overflow <= 1'b0;
        count    <= 4'd0;
      end
    end
  end

endmodule
